// File: rtl/decoder_3to8_if.sv
// Decoder bus: binary select in, one-hot strobes out.
// The master drives the index and enable; the decoder (slave) returns
// the registered one-hot vector with its valid and error flags.
interface decoder_3to8_if #(
   parameter int IN  = 3,
   parameter int OUT = 8
);
   logic [IN-1:0]  in;
   logic           enable;
   logic [OUT-1:0] out;
   logic           out_valid;
   logic           err;

   modport master (
      output in,
      output enable,
      input  out,
      input  out_valid,
      input  err
   );

   modport slave (
      input  in,
      input  enable,
      output out,
      output out_valid,
      output err
   );
endinterface

// File: rtl/decoder_3to8.sv
// Binary-to-one-hot decoder with enable and a single registered output stage.
// An index with no output line (in >= OUT) yields an all-idle vector and
// raises err instead of aliasing onto a lower line. OUT_ACTIVE_LOW flips the
// polarity of the strobes only; out_valid and err stay active-high.
module decoder_3to8 #(
   parameter int IN             = 3,
   parameter int OUT            = 8,
   parameter int OUT_ACTIVE_LOW = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   decoder_3to8_if.slave bus
);

   // OUT can equal 2**IN, so the range limit needs one extra bit.
   localparam logic [IN:0]    OUT_LIM  = (IN+1)'(OUT);
   localparam logic [OUT-1:0] POL_MASK = (OUT_ACTIVE_LOW != 0) ? {OUT{1'b1}} : {OUT{1'b0}};

   logic [OUT-1:0] w_dec_p0;
   logic           w_err_p0;

   logic [OUT-1:0] r_out_p1;
   logic           r_vld_p1;
   logic           r_err_p1;

   // ---- stage p0: combinational decode of the sampled index ----
   // Decode only under enable so an unknown index while idle cannot reach out.
   always_comb begin
      w_dec_p0 = '0;
      w_err_p0 = 1'b0;
      if (bus.enable) begin
         for (int i = 0; i < OUT; i++) begin
            if (bus.in == IN'(i)) begin
               w_dec_p0[i] = 1'b1;
            end
         end
         w_err_p0 = ({1'b0, bus.in} >= OUT_LIM);
      end
   end

   // ---- stage p1: output register, polarity applied on the way in ----
   // Reset drives the logical-idle value, i.e. all ones when active-low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_p1 <= POL_MASK;
         r_vld_p1 <= 1'b0;
         r_err_p1 <= 1'b0;
      end else begin
         r_out_p1 <= w_dec_p0 ^ POL_MASK;
         r_vld_p1 <= bus.enable;
         r_err_p1 <= w_err_p0;
      end
   end

   assign bus.out       = r_out_p1;
   assign bus.out_valid = r_vld_p1;
   assign bus.err       = r_err_p1;

endmodule

// File: tb/tb_decoder_3to8.sv
// Bench for decoder_3to8: three configurations driven in lockstep
// (default 3->8, 3->6 with out-of-range codes, and 3->8 active-low).
module tb_decoder_3to8;

   logic clk;
   logic rst_n;

   decoder_3to8_if #(.IN(3), .OUT(8)) b0 ();
   decoder_3to8_if #(.IN(3), .OUT(6)) b1 ();
   decoder_3to8_if #(.IN(3), .OUT(8)) b2 ();

   decoder_3to8 #(.IN(3), .OUT(8), .OUT_ACTIVE_LOW(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   decoder_3to8 #(.IN(3), .OUT(6), .OUT_ACTIVE_LOW(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   decoder_3to8 #(.IN(3), .OUT(8), .OUT_ACTIVE_LOW(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] o0;
      logic [7:0] o1;
      logic [7:0] o2;
      logic       vld;
      logic       e0;
      logic       e1;
      logic       e2;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_mis = 0;
   int   n_step = 0;

   // Reference: one-hot of idx when enabled and idx has a line, else idle.
   function automatic logic [7:0] ref_out(logic [2:0] idx, logic en, int n_out, bit al);
      logic [7:0] v;
      logic [7:0] mask;
      v = 8'h00;
      if (en === 1'b1) begin
         case (idx)
            3'd0: v = 8'h01;
            3'd1: v = 8'h02;
            3'd2: v = 8'h04;
            3'd3: v = 8'h08;
            3'd4: v = 8'h10;
            3'd5: v = 8'h20;
            3'd6: v = 8'h40;
            default: v = 8'h80;
         endcase
         if (int'(idx) >= n_out) v = 8'h00;
      end
      mask = (n_out == 6) ? 8'h3F : 8'hFF;
      if (al) v = ~v;
      return v & mask;
   endfunction

   function automatic logic ref_err(logic [2:0] idx, logic en, int n_out);
      if (en !== 1'b1) return 1'b0;
      return (int'(idx) >= n_out);
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " u0.out"}, b0.out, 8'h00);
      chk({tag, " u1.out"}, {2'b00, b1.out}, 8'h00);
      chk({tag, " u2.out"}, b2.out, 8'hFF);
      chk({tag, " valid"}, {5'd0, b0.out_valid, b1.out_valid, b2.out_valid}, 8'h00);
      chk({tag, " err"}, {5'd0, b0.err, b1.err, b2.err}, 8'h00);
   endtask

   task automatic drive(input logic [2:0] idx, input logic en);
      exp_t e;
      b0.in = idx; b1.in = idx; b2.in = idx;
      b0.enable = en; b1.enable = en; b2.enable = en;
      e.o0  = ref_out(idx, en, 8, 1'b0);
      e.o1  = ref_out(idx, en, 6, 1'b0);
      e.o2  = ref_out(idx, en, 8, 1'b1);
      e.vld = en;
      e.e0  = ref_err(idx, en, 8);
      e.e1  = ref_err(idx, en, 6);
      e.e2  = ref_err(idx, en, 8);
      q.push_back(e);
   endtask

   task automatic step(input logic [2:0] idx, input logic en);
      exp_t e;
      string t;
      @(negedge clk);
      drive(idx, en);
      @(posedge clk);
      #1;
      n_step++;
      t = $sformatf("step%0d in=%b en=%b", n_step, idx, en);
      if (q.size() == 0) begin
         chk({t, " scoreboard empty"}, 8'h01, 8'h00);
      end else begin
         e = q.pop_front();
         chk({t, " u0.out"}, b0.out, e.o0);
         chk({t, " u1.out"}, {2'b00, b1.out}, e.o1);
         chk({t, " u2.out"}, b2.out, e.o2);
         chk({t, " valid"}, {5'd0, b0.out_valid, b1.out_valid, b2.out_valid}, {5'd0, e.vld, e.vld, e.vld});
         chk({t, " err"}, {5'd0, b0.err, b1.err, b2.err}, {5'd0, e.e0, e.e1, e.e2});
      end
   endtask

   initial begin
      rst_n = 1'b1;
      b0.in = 3'd0; b1.in = 3'd0; b2.in = 3'd0;
      b0.enable = 1'b1; b1.enable = 1'b1; b2.enable = 1'b1;
      // Asynchronous reset between clock edges, checked before any edge.
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("async reset");
      @(posedge clk);
      #1;
      chk_reset("held reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Sweep with enable high.
      step(3'b001, 1'b1);
      step(3'b101, 1'b1);
      step(3'b111, 1'b1);
      step(3'b011, 1'b1);
      step(3'b100, 1'b1);
      // Disable with index held, then toggle index while disabled.
      step(3'b100, 1'b0);
      step(3'b010, 1'b0);
      step(3'b111, 1'b0);
      step(3'bxxx, 1'b0);
      // Back-to-back, one new index per cycle.
      for (int i = 0; i < 8; i++) step(3'(i), 1'b1);
      // Out-of-range codes for the 6-line instance, and polarity checks.
      step(3'd6, 1'b1);
      step(3'd7, 1'b1);
      step(3'd5, 1'b1);
      step(3'd2, 1'b1);
      step(3'd2, 1'b0);
      // Simultaneous change of index and enable.
      step(3'd6, 1'b1);
      step(3'd0, 1'b0);
      step(3'd3, 1'b1);

      // Reset mid-operation: outputs drop at once, in-flight sample discarded.
      @(negedge clk);
      drive(3'd5, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("mid-op reset");
      @(posedge clk);
      #1;
      chk_reset("mid-op reset held");
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      // First decode after release.
      step(3'd4, 1'b1);
      step(3'd1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
